// File: rtl/sigmoid_pkg.sv
// Fixed-point constants shared by sigmoid8_piped and its output collector.
// Samples are sign-magnitude with 11 fraction bits; 1.0 is 0x0800.
package sigmoid_pkg;

  localparam int FRAC_BITS    = 11;
  localparam int ONE          = 1 << FRAC_BITS;
  localparam int SIG_BITSIZE  = 16;
  localparam int SIGN_BIT     = SIG_BITSIZE - 1;

  function automatic int sign_bit_of(input int bitsize);
    return bitsize - 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; head entry visible on rd_data while not empty.
// Latency: write visible at the head one edge later. Push+pop when full both succeed.
// Backpressure: none internally; a write while full (without pop) is dropped and flagged on wr_drop.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   wr_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a push against a full FIFO still lands.
  assign do_wr   = wr_en & (~full | do_rd);
  assign wr_drop = wr_en & full & ~do_rd;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sigmoid_out_collector.sv
// Collects clamped sigmoid8_piped results into a FWFT FIFO and tags frame ends.
// Latency: LATENCY+1 edges from accepted in_valid to out_valid when empty.
// Backpressure: credit-based; in_ready drops once stored + in-flight results reach DEPTH.
module sigmoid_out_collector
  import sigmoid_pkg::*;
#(
  parameter int BITSIZE   = 16,
  parameter int LATENCY   = 3,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BITSIZE-1:0]     sig_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITSIZE-1:0]     out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   ovf_err
);

  localparam int SB = sign_bit_of(BITSIZE);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [LATENCY-1:0] valid_pipe;
  logic               accept;
  logic               tail_vld;
  logic               pop;
  logic               fifo_empty;
  logic               wr_drop;
  logic [BITSIZE-1:0] clamp_dat;
  logic [FW-1:0]      frame_cnt;
  int                 credit;

  assign accept   = in_valid & in_ready;
  assign tail_vld = valid_pipe[LATENCY-1];
  assign out_valid = ~fifo_empty;
  assign pop      = out_valid & out_ready;
  assign out_last = out_valid & (frame_cnt == FW'(FRAME_LEN - 1));

  // Pops are ignored here so in_ready depends only on flops; costs at most one cycle of credit.
  always_comb begin
    credit = int'(fill_level);
    for (int i = 0; i < LATENCY; i++) credit += int'(valid_pipe[i]);
    in_ready = (credit < DEPTH);
  end

  always_comb begin
    clamp_dat = sig_data;
    if (sig_data[SB])                      clamp_dat = '0;
    else if (sig_data > BITSIZE'(ONE))     clamp_dat = BITSIZE'(ONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_pipe <= '0;
      frame_cnt  <= '0;
      ovf_err    <= 1'b0;
    end else begin
      valid_pipe <= (valid_pipe << 1) | LATENCY'(accept);
      if (pop) frame_cnt <= (frame_cnt == FW'(FRAME_LEN - 1)) ? '0 : frame_cnt + FW'(1);
      if (wr_drop) ovf_err <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (BITSIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tail_vld),
    .wr_data (clamp_dat),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .count   (fill_level),
    .empty   (fifo_empty),
    .wr_drop (wr_drop)
  );

endmodule

// File: tb/tb_sigmoid_out_collector.sv
// Directed bench for sigmoid_out_collector; models sigmoid8_piped as a 3-stage delay of stim.
module tb_sigmoid_out_collector;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sig_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic [3:0]  fill_level;
  logic        ovf_err;

  int checks   = 0;
  int failures = 0;

  logic [15:0] stim, d0, d1, d2;
  int          n_acc;
  logic [15:0] pop_q[$];
  logic        last_q[$];
  logic [15:0] exp_q[$];

  sigmoid_out_collector #(
    .BITSIZE(16), .LATENCY(3), .DEPTH(8), .FRAME_LEN(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sig_data   (sig_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .fill_level (fill_level),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // Records handshakes of the current cycle, advances one edge, then shifts the upstream model.
  task automatic tick();
    logic acc, pp, pl;
    logic [15:0] pd;
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    pd  = out_data;
    pl  = out_last;
    if (acc) begin n_acc++; exp_q.push_back(stim); end
    if (pp)  begin pop_q.push_back(pd); last_q.push_back(pl); end
    @(posedge clk); #1;
    d2 = d1; d1 = d0; d0 = stim; sig_data = d2;
  endtask

  task automatic apply_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    stim = '0; d0 = '0; d1 = '0; d2 = '0; sig_data = '0;
    tick(); tick();
    reset = 1'b1;
    n_acc = 0; pop_q.delete(); last_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    stim = '0; d0 = '0; d1 = '0; d2 = '0; sig_data = '0; n_acc = 0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%0b exp=0", out_last); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
    checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf_err); end
    reset = 1'b1;
  endtask

  task automatic test_latency();
    apply_reset();
    in_valid = 1'b1; stim = 16'h0400; tick();
    in_valid = 1'b0; stim = 16'h0000; tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_edge2_valid got=%0b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_edge3_valid got=%0b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_edge4_valid got=%0b exp=1", out_valid); end
    checks++; if (out_data !== 16'h0400) begin failures++; $display("FAIL lat_data got=%h exp=0400", out_data); end
    checks++; if (fill_level !== 4'd1) begin failures++; $display("FAIL lat_fill got=%0d exp=1", fill_level); end
    out_ready = 1'b1; tick();
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL lat_pop_fill got=%0d exp=0", fill_level); end
  endtask

  task automatic test_clamp();
    logic [15:0] vals [6] = '{16'h8010, 16'h0900, 16'h07FF, 16'h0800, 16'h0801, 16'hFFFF};
    logic [15:0] expv [6] = '{16'h0000, 16'h0800, 16'h07FF, 16'h0800, 16'h0800, 16'h0000};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin in_valid = 1'b1; stim = vals[i]; tick(); end
    in_valid = 1'b0; stim = '0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (pop_q.size() != 6) begin failures++; $display("FAIL clamp_count got=%0d exp=6", pop_q.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < pop_q.size()) begin
        checks++;
        if (pop_q[i] !== expv[i]) begin failures++; $display("FAIL clamp_%0d in=%h got=%h exp=%h", i, vals[i], pop_q[i], expv[i]); end
      end
    end
  endtask

  task automatic test_fill();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 7) begin checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_rdy_at7 got=%0b exp=1", in_ready); end end
      if (i == 8) begin checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_rdy_at8 got=%0b exp=0", in_ready); end end
      in_valid = 1'b1; stim = 16'(i + 1); tick();
    end
    checks++; if (n_acc != 8) begin failures++; $display("FAIL fill_accepts got=%0d exp=8", n_acc); end
    checks++; if (fill_level !== 4'd8) begin failures++; $display("FAIL fill_level got=%0d exp=8", fill_level); end
    checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL fill_ovf got=%0b exp=0", ovf_err); end
    checks++; if (out_data !== 16'h0001) begin failures++; $display("FAIL fill_head got=%h exp=0001", out_data); end
  endtask

  // Continues from the full FIFO left by test_fill.
  task automatic test_back_to_back();
    int steady_bad = 0;
    int bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; stim = 16'(100 + i); tick();
      if (i >= 10 && fill_level != 4'd4) steady_bad++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (steady_bad != 0) begin failures++; $display("FAIL b2b_steady_fill off_cycles=%0d exp=0", steady_bad); end
    checks++; if (n_acc != 37) begin failures++; $display("FAIL b2b_accepts got=%0d exp=37", n_acc); end
    checks++; if (pop_q.size() != 37) begin failures++; $display("FAIL b2b_pops got=%0d exp=37", pop_q.size()); end
    for (int i = 0; i < 37; i++) begin
      if (i >= pop_q.size() || i >= exp_q.size()) bad++;
      else if (pop_q[i] !== exp_q[i]) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_order bad_entries=%0d exp=0", bad); end
    checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%0b exp=0", ovf_err); end
  endtask

  task automatic test_frame();
    int bad = 0;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin in_valid = 1'b1; stim = 16'(i); tick(); end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (n_acc != 40) begin failures++; $display("FAIL frame_accepts got=%0d exp=40", n_acc); end
    checks++; if (pop_q.size() != 40) begin failures++; $display("FAIL frame_pops got=%0d exp=40", pop_q.size()); end
    for (int j = 0; j < last_q.size(); j++)
      if (last_q[j] !== ((j == 15) || (j == 31))) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL frame_last_pos bad=%0d exp=0", bad); end
    pop_q.delete(); last_q.delete(); bad = 0;
    for (int i = 0; i < 8; i++) begin in_valid = 1'b1; stim = 16'(50 + i); tick(); end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (last_q.size() != 8) begin failures++; $display("FAIL frame_tail_pops got=%0d exp=8", last_q.size()); end
    for (int j = 0; j < last_q.size(); j++)
      if (last_q[j] !== (j == 7)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL frame_counter_at8 bad=%0d exp=0", bad); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin in_valid = 1'b1; stim = 16'(200 + i); tick(); end
    in_valid = 1'b0; stim = 16'h0123; tick();
    checks++; if (fill_level !== 4'd5) begin failures++; $display("FAIL mid_pre_fill got=%0d exp=5", fill_level); end
    reset = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%0b exp=0", out_valid); end
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL mid_fill got=%0d exp=0", fill_level); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL mid_out_last got=%0b exp=0", out_last); end
    tick();
    reset = 1'b1;
    pop_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (pop_q.size() != 0) begin failures++; $display("FAIL mid_stale_pops got=%0d exp=0", pop_q.size()); end
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL mid_post_fill got=%0d exp=0", fill_level); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_clamp();
    test_fill();
    test_back_to_back();
    test_frame();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
